// File: rtl/act_skew_feeder.sv
// Activation skew feeder: staggers each input vector across N lanes so lane i
// reaches the systolic grid i advances later, then flushes zeros to drain the wavefront.
module act_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((N > 1) ? N - 2 : 0);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                          state, state_nxt;
  logic [CW-1:0]                   cnt, cnt_nxt;
  logic                            done_nxt, accept, flush, adv;
  logic [N-1:0][DATA_WIDTH-1:0]    lane_out;

  assign in_ready = (state != FLUSH);
  assign busy     = (state != IDLE);
  assign flush    = (state == FLUSH);
  assign accept   = in_valid && in_ready;
  assign adv      = accept || flush;
  assign out_data = lane_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= adv;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (!in_last) begin
            state_nxt = STREAM;
          end else if (N == 1) begin
            // Single lane has nothing to drain: the last beat is also the final one.
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
          end
        end
      end
      FLUSH: begin
        if (cnt == LAST_CNT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zeros are injected while flushing so every delay line drains clean.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] inj;
    assign inj = flush ? '0 : in_data[i*DATA_WIDTH +: DATA_WIDTH];
    act_skew_lane #(.DEPTH(i + 1), .DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk  (clk),
      .reset(reset),
      .adv  (adv),
      .din  (inj),
      .dout (lane_out[i])
    );
  end

endmodule

// Per-lane delay line: the last stage is the lane's output register, so it holds
// across bubbles while the earlier stages carry the pending skew.
module act_skew_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adv,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (adv) begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder at N=4, DATA_WIDTH=8.
module tb_act_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last;
  logic [N*DW-1:0] in_data, out_data;
  logic          out_valid, busy, done;

  int n_chk = 0;
  int n_err = 0;

  act_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [N*DW-1:0] exp_d, input logic exp_done);
    chk({tag, ".vld"}, 64'(out_valid), 64'(1));
    chk({tag, ".dat"}, 64'(out_data), 64'(exp_d));
    chk({tag, ".done"}, 64'(done), 64'(exp_done));
  endtask

  task automatic drive(input logic v, input logic [N*DW-1:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".vld"}, 64'(out_valid), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".rdy"}, 64'(in_ready), 64'(1));
  endtask

  task automatic single_1234(input string tag);
    drive(1'b1, pk(1, 2, 3, 4), 1'b1);
    step();
    drive(1'b0, pk(7, 7, 7, 7), 1'b1);
    beat({tag, ".b1"}, pk(1, 0, 0, 0), 1'b0);
    chk({tag, ".rdy1"}, 64'(in_ready), 64'(0));
    chk({tag, ".busy1"}, 64'(busy), 64'(1));
    step(); beat({tag, ".b2"}, pk(0, 2, 0, 0), 1'b0);
    chk({tag, ".rdy2"}, 64'(in_ready), 64'(0));
    step(); beat({tag, ".b3"}, pk(0, 0, 3, 0), 1'b0);
    chk({tag, ".rdy3"}, 64'(in_ready), 64'(0));
    step(); beat({tag, ".b4"}, pk(0, 0, 0, 4), 1'b1);
    chk({tag, ".rdy4"}, 64'(in_ready), 64'(1));
    step();
    idle_chk({tag, ".end"});
    chk({tag, ".hold"}, 64'(out_data), 64'(pk(0, 0, 0, 4)));
  endtask

  task automatic stream_123(input string tag, input int gap);
    drive(1'b1, pk(1, 1, 1, 1), 1'b0);
    step(); beat({tag, ".b1"}, pk(1, 0, 0, 0), 1'b0);
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    chk({tag, ".rdy"}, 64'(in_ready), 64'(1));
    for (int g = 0; g < gap; g++) begin
      drive(1'b0, pk(5, 5, 5, 5), 1'b1);
      step();
      chk({tag, ".gvld"}, 64'(out_valid), 64'(0));
      chk({tag, ".gdat"}, 64'(out_data), 64'(pk(1, 0, 0, 0)));
    end
    drive(1'b1, pk(2, 2, 2, 2), 1'b0);
    step(); beat({tag, ".b2"}, pk(2, 1, 0, 0), 1'b0);
    drive(1'b1, pk(3, 3, 3, 3), 1'b1);
    step(); beat({tag, ".b3"}, pk(3, 2, 1, 0), 1'b0);
    drive(1'b0, pk(0, 0, 0, 0), 1'b0);
    step(); beat({tag, ".b4"}, pk(0, 3, 2, 1), 1'b0);
    step(); beat({tag, ".b5"}, pk(0, 0, 3, 2), 1'b0);
    step(); beat({tag, ".b6"}, pk(0, 0, 0, 3), 1'b1);
    step();
    idle_chk({tag, ".end"});
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (3) step();
    chk("rst.dat", 64'(out_data), 64'(0));
    idle_chk("rst");
    reset = 1'b1;
    step();
    idle_chk("post_rst");

    single_1234("single");
    stream_123("b2b", 0);
    stream_123("gap", 2);

    // Upstream keeps offering 9s throughout FLUSH; only the done cycle may take them.
    drive(1'b1, pk(5, 6, 7, 8), 1'b1);
    step(); beat("hold.b1", pk(5, 0, 0, 0), 1'b0);
    drive(1'b1, pk(9, 9, 9, 9), 1'b1);
    step(); beat("hold.b2", pk(0, 6, 0, 0), 1'b0);
    step(); beat("hold.b3", pk(0, 0, 7, 0), 1'b0);
    step(); beat("hold.b4", pk(0, 0, 0, 8), 1'b1);
    chk("hold.rdy", 64'(in_ready), 64'(1));
    step(); beat("hold.n1", pk(9, 0, 0, 0), 1'b0);
    drive(1'b0, '0, 1'b0);
    step(); beat("hold.n2", pk(0, 9, 0, 0), 1'b0);
    step(); beat("hold.n3", pk(0, 0, 9, 0), 1'b0);
    step(); beat("hold.n4", pk(0, 0, 0, 9), 1'b1);
    step();
    idle_chk("hold.end");

    // Reset lands during the second flush beat.
    drive(1'b1, pk(1, 2, 3, 4), 1'b1);
    step(); beat("mid.b1", pk(1, 0, 0, 0), 1'b0);
    drive(1'b0, '0, 1'b0);
    step(); beat("mid.b2", pk(0, 2, 0, 0), 1'b0);
    reset = 1'b0;
    #1;
    chk("mid.dat", 64'(out_data), 64'(0));
    idle_chk("mid.rst");
    step(); step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      idle_chk("mid.quiet");
    end
    single_1234("again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 4, the systolic grid dimension and lane count (N >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the activation element width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream presents one activation vector.
REQ-006 SHALL have port in_ready  output  1  feeder accepts the vector this cycle.
REQ-007 SHALL have port in_data  input  N*DATA_WIDTH  vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port in_last  input  1  qualifies the final vector of a transaction.
REQ-009 SHALL have port out_data  output  N*DATA_WIDTH  skewed activations for the grid's left inputs, same lane packing.
REQ-010 SHALL have port out_valid  output  1  advance strobe; the top level drives the grid enable from it.
REQ-011 SHALL have port busy  output  1  high in STREAM or FLUSH.
REQ-012 SHALL have port done  output  1  one-cycle pulse on the final flush beat.

Function
REQ-013 SHALL implement FSM states IDLE, STREAM, FLUSH.
REQ-014 SHALL drive in_ready = 1 in IDLE and STREAM, 0 in FLUSH.
REQ-015 SHALL define accept as in_valid && in_ready at a rising edge.
REQ-016 SHALL define an advance as an edge with accept, or any edge in FLUSH; skew state SHALL change only on advances.
REQ-017 SHALL register out_valid: high in the cycle after each advance, low otherwise.
REQ-018 SHALL, after an advance, present in out_data lane i the lane-i element injected i advances earlier; lane 0 is the current element; injections before transaction start count as 0.
REQ-019 SHALL inject an all-zero vector on every FLUSH advance.
REQ-020 SHALL hold out_data unchanged in cycles with out_valid = 0 (upstream bubble), preserving alignment.
REQ-021 SHALL transition IDLE -> STREAM on accept with in_last = 0.
REQ-022 SHALL transition IDLE or STREAM -> FLUSH on accept with in_last = 1 when N > 1.
REQ-023 SHALL, when N = 1, treat an accept with in_last = 1 as the final beat: assert done in the next cycle and go to IDLE.
REQ-024 SHALL remain in FLUSH for exactly N-1 advances, counted by a clog2(N)-bit counter, then return to IDLE.
REQ-025 SHALL assert done in the same cycle as the out_valid beat of the last flush advance, for exactly one cycle.
REQ-026 SHALL leave all skew registers at zero after FLUSH completes, so the next transaction starts clean.
REQ-027 SHALL allow accept in the cycle done is high (state already IDLE), with no lost or merged beat.
REQ-028 SHALL ignore in_data and in_last when in_valid = 0.

Reset
REQ-029 SHALL, on reset low, asynchronously force state IDLE, the flush counter and all skew registers to 0, out_data = 0, out_valid = 0, done = 0, and busy = 0.
REQ-030 SHALL drive in_ready = 1 while in reset and after release.
REQ-031 SHALL discard any in-progress transaction on reset mid-STREAM or mid-FLUSH, with no done pulse.

Verification (N=4, DATA_WIDTH=8, lanes listed 0..3)
REQ-032 Reset low for 3 cycles -> out_data = 0, out_valid = 0, done = 0, busy = 0, in_ready = 1.
REQ-033 Single vector {1,2,3,4} with in_last = 1 -> four consecutive out_valid beats {1,0,0,0}, {0,2,0,0}, {0,0,3,0}, {0,0,0,4}; in_ready = 0 for 3 cycles; done on beat 4 only.
REQ-034 Back-to-back vectors {1,1,1,1}, {2,2,2,2}, {3,3,3,3} (last) -> beats {1,0,0,0}, {2,1,0,0}, {3,2,1,0}, {0,3,2,1}, {0,0,3,2}, {0,0,0,3}; done on beat 6.
REQ-035 Same stream with a 2-cycle in_valid gap after vector 1 -> out_valid low for 2 cycles, out_data held at {1,0,0,0}, remaining beats identical to REQ-034.
REQ-036 in_valid held high during FLUSH with data 9 -> no accept; 9 is taken as the first element of the next transaction in the done cycle, producing {9,0,0,0}.
REQ-037 Reset asserted on the second FLUSH beat -> all outputs 0 immediately, no done, in_ready = 1, a subsequent single-vector transaction matches REQ-033.
